// File: rtl/multicycle_control_fsm.sv
// Main control FSM for a multicycle datapath.
// Sequences fetch, decode, memory, ALU and branch steps.
module multicycle_control_fsm #(
  parameter int STALL_EN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  typedef struct packed {
    logic       adr;
    logic       aluop;
    logic       regw;
    logic       memw;
    logic       branch;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] res;
  } ctl_t;

  state_t state;
  state_t nxt;
  ctl_t   ctl_q;
  logic   rdy;
  logic   unused_funct;

  assign unused_funct = ^Funct[4:1];

  // With stalling disabled every memory access completes at once.
  assign rdy = (STALL_EN != 0) ? MemReady : 1'b1;

  // Per-state datapath controls; unlisted fields stay zero.
  function automatic ctl_t ctl_of(state_t s);
    ctl_t c;
    c = '0;
    unique case (s)
      FETCH: begin
        c.srca = 2'b01;
        c.srcb = 2'b10;
        c.res  = 2'b10;
      end
      DECODE: begin
        c.srca = 2'b01;
        c.srcb = 2'b10;
        c.res  = 2'b10;
      end
      MEMADR: begin
        c.srcb = 2'b01;
      end
      MEMRD: begin
        c.adr = 1'b1;
      end
      MEMWB: begin
        c.res  = 2'b01;
        c.regw = 1'b1;
      end
      MEMWR: begin
        c.adr  = 1'b1;
        c.memw = 1'b1;
      end
      EXECR: begin
        c.aluop = 1'b1;
      end
      EXECI: begin
        c.srcb  = 2'b01;
        c.aluop = 1'b1;
      end
      ALUWB: begin
        c.regw = 1'b1;
      end
      BRANCH: begin
        c.srca   = 2'b10;
        c.srcb   = 2'b01;
        c.res    = 2'b10;
        c.branch = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state selection; Op/Funct only matter in DECODE and MEMADR.
  always_comb begin
    nxt = FETCH;
    unique case (state)
      FETCH:  nxt = rdy ? DECODE : FETCH;
      DECODE: begin
        unique case (1'b1)
          Op == 2'b01: nxt = MEMADR;
          Op == 2'b00: nxt = Funct[5] ? EXECI : EXECR;
          Op == 2'b10: nxt = BRANCH;
          default:     nxt = FETCH;
        endcase
      end
      MEMADR: nxt = Funct[0] ? MEMRD : MEMWR;
      MEMRD:  nxt = rdy ? MEMWB : MEMRD;
      MEMWB:  nxt = FETCH;
      MEMWR:  nxt = rdy ? FETCH : MEMWR;
      EXECR:  nxt = ALUWB;
      EXECI:  nxt = ALUWB;
      ALUWB:  nxt = FETCH;
      BRANCH: nxt = FETCH;
      default: nxt = FETCH;
    endcase
  end

  // State register with controls registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      ctl_q <= ctl_of(FETCH);
    end else begin
      state <= nxt;
      ctl_q <= ctl_of(nxt);
    end
  end

  // Strobes are forced low while reset is held.
  assign IRWrite   = (state == FETCH) & rdy & ~reset;
  assign NextPC    = (state == FETCH) & rdy & ~reset;
  assign Illegal   = (state == DECODE) & (Op == 2'b11) & ~reset;
  assign RegW      = ctl_q.regw & ~reset;
  assign MemW      = ctl_q.memw & ~reset;
  assign Branch    = ctl_q.branch & ~reset;
  assign ALUOp     = ctl_q.aluop;
  assign AdrSrc    = ctl_q.adr;
  assign ALUSrcA   = ctl_q.srca;
  assign ALUSrcB   = ctl_q.srcb;
  assign ResultSrc = ctl_q.res;
  assign State     = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm.
// Instruction-level reference model with random stalls and operands.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       MemReady = 1'b0;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'd0;

  logic       irw0, npc0, rw0, mw0, br0, aop0, adr0, ill0;
  logic [1:0] sa0, sb0, rs0;
  logic [3:0] st0;
  logic       irw1, npc1, rw1, mw1, br1, aop1, adr1, ill1;
  logic [1:0] sa1, sb1, rs1;
  logic [3:0] st1;

  logic [17:0] obs0;
  assign obs0 = {irw0, npc0, rw0, mw0, br0, aop0, adr0, ill0,
                 sa0, sb0, rs0, st0};

  localparam logic [17:0] STROBES = 18'h3E400;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.STALL_EN(1)) u0 (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
    .MemReady(MemReady),
    .IRWrite(irw0), .NextPC(npc0), .RegW(rw0), .MemW(mw0),
    .Branch(br0), .ALUOp(aop0), .AdrSrc(adr0),
    .ALUSrcA(sa0), .ALUSrcB(sb0), .ResultSrc(rs0),
    .Illegal(ill0), .State(st0)
  );

  multicycle_control_fsm #(.STALL_EN(0)) u1 (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
    .MemReady(1'b0),
    .IRWrite(irw1), .NextPC(npc1), .RegW(rw1), .MemW(mw1),
    .Branch(br1), .ALUOp(aop1), .AdrSrc(adr1),
    .ALUSrcA(sa1), .ALUSrcB(sb1), .ResultSrc(rs1),
    .Illegal(ill1), .State(st1)
  );

  // Expected outputs for a step of the instruction flow.
  function automatic logic [17:0] exp_vec(int st, bit rdy,
                                          logic [1:0] op);
    logic irw, npc, rw, mw, br, aop, adr, ill;
    logic [1:0] a, b, r;
    irw = 0; npc = 0; rw = 0; mw = 0; br = 0;
    aop = 0; adr = 0; ill = 0;
    a = 2'b00; b = 2'b00; r = 2'b00;
    case (st)
      0: begin a = 2'b01; b = 2'b10; r = 2'b10;
               irw = rdy; npc = rdy; end
      1: begin a = 2'b01; b = 2'b10; r = 2'b10;
               ill = (op == 2'b11); end
      2: b = 2'b01;
      3: adr = 1;
      4: begin r = 2'b01; rw = 1; end
      5: begin adr = 1; mw = 1; end
      6: aop = 1;
      7: begin b = 2'b01; aop = 1; end
      8: rw = 1;
      9: begin a = 2'b10; b = 2'b01; r = 2'b10; br = 1; end
      default: ;
    endcase
    return {irw, npc, rw, mw, br, aop, adr, ill, a, b, r, 4'(st)};
  endfunction

  // Build the expected step list for one instruction and play it.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] fn,
                           input int sf, input int sm, input string nm);
    int seq[$];
    bit rd[$];
    logic [17:0] exp;
    for (int k = 0; k <= sf; k++) begin
      seq.push_back(0); rd.push_back(k == sf);
    end
    seq.push_back(1); rd.push_back(1'($urandom));
    case (op)
      2'b01: begin
        seq.push_back(2); rd.push_back(1'($urandom));
        for (int k = 0; k <= sm; k++) begin
          seq.push_back(fn[0] ? 3 : 5); rd.push_back(k == sm);
        end
        if (fn[0]) begin
          seq.push_back(4); rd.push_back(1'($urandom));
        end
      end
      2'b00: begin
        seq.push_back(fn[5] ? 7 : 6); rd.push_back(1'($urandom));
        seq.push_back(8); rd.push_back(1'($urandom));
      end
      2'b10: begin
        seq.push_back(9); rd.push_back(1'($urandom));
      end
      default: ;
    endcase
    for (int i = 0; i < seq.size(); i++) begin
      @(negedge clk);
      MemReady = rd[i];
      if (seq[i] == 1 || seq[i] == 2) begin
        Op = op; Funct = fn;
      end else begin
        Op = 2'($urandom); Funct = 6'($urandom);
      end
      #1;
      exp = exp_vec(seq[i], rd[i], Op);
      n_cmp++;
      if (obs0 !== exp) begin
        n_bad++;
        $display("FAIL %s step%0d: got %h want %h", nm, i, obs0, exp);
      end
    end
  endtask

  task automatic test_reset();
    logic [17:0] exp;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    MemReady = 1'b1;
    #1;
    exp = exp_vec(0, 1'b0, Op);
    n_cmp++;
    if (obs0 !== exp) begin
      n_bad++;
      $display("FAIL reset_state: got %h want %h", obs0, exp);
    end
    n_cmp++;
    if (irw1 !== 1'b0 || st1 !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_nostall: got irw=%b st=%0d want 0/0",
               irw1, st1);
    end
    MemReady = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_load();
    run_instr(2'b01, 6'b000001, 0, 0, "load");
  endtask

  task automatic test_store_stall();
    run_instr(2'b01, 6'b000000, 0, 3, "store_stall");
  endtask

  task automatic test_dataproc();
    run_instr(2'b00, 6'b000000, 0, 0, "dp_reg");
    run_instr(2'b00, 6'b100000, 0, 0, "dp_imm");
  endtask

  task automatic test_branch();
    run_instr(2'b10, 6'($urandom), 0, 0, "branch");
  endtask

  task automatic test_fetch_stall_illegal();
    run_instr(2'b11, 6'($urandom), 2, 0, "fetch_stall_undef");
    run_instr(2'b10, 6'($urandom), 0, 0, "after_undef");
  endtask

  task automatic test_reset_midstall(input bit store);
    int st;
    logic [17:0] exp;
    int seq[5];
    st = store ? 5 : 3;
    seq = '{0, 1, 2, st, st};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      MemReady = (i == 0);
      Op = 2'b01;
      Funct = {5'($urandom), ~store};
      #1;
      exp = exp_vec(seq[i], MemReady, Op);
      n_cmp++;
      if (obs0 !== exp) begin
        n_bad++;
        $display("FAIL midstall_pre step%0d: got %h want %h",
                 i, obs0, exp);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    MemReady = 1'b0;
    #1;
    exp = exp_vec(st, 1'b0, Op) & ~STROBES;
    n_cmp++;
    if (obs0 !== exp) begin
      n_bad++;
      $display("FAIL midstall_rst_held: got %h want %h", obs0, exp);
    end
    @(negedge clk);
    MemReady = 1'b1;
    #1;
    exp = exp_vec(0, 1'b0, Op);
    n_cmp++;
    if (obs0 !== exp) begin
      n_bad++;
      $display("FAIL midstall_rst_fetch: got %h want %h", obs0, exp);
    end
    MemReady = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_nostall();
    int exp_st[6];
    exp_st = '{0, 1, 2, 3, 4, 0};
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    Op = 2'b01;
    Funct = 6'b000001;
    MemReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_cmp++;
      if (st1 !== 4'(exp_st[i])) begin
        n_bad++;
        $display("FAIL nostall_load step%0d: got %0d want %0d",
                 i, st1, exp_st[i]);
      end
    end
    n_cmp++;
    if (irw1 !== 1'b1) begin
      n_bad++;
      $display("FAIL nostall_irwrite: got %b want 1", irw1);
    end
    MemReady = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] op;
    logic [5:0] fn;
    for (int n = 0; n < 150; n++) begin
      op = 2'($urandom);
      fn = 6'($urandom);
      run_instr(op, fn, int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_stall();
    test_dataproc();
    test_branch();
    test_fetch_stall_illegal();
    test_reset_midstall(1'b0);
    test_reset_midstall(1'b1);
    test_back_to_back();
    test_nostall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
